fetch_prefetch_unit: RTL
========================

# fetch_prefetch_unit

Instruction fetch front end for the 5-stage 8-bit pipelined core. It owns the fetch PC, issues addresses to a synchronous (1-cycle latency) 256×16 instruction memory, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and squash in-flight fetches.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 8'h00, fetch PC loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  8  fetch address; equals fpc
- imem_data  in  16  instruction word, valid in the cycle after the request
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  8  new fetch target
- inst  out  16  head instruction
- inst_pc  out  8  PC of head instruction
- inst_pcinc  out  8  inst_pc + 1, mod 256
- inst_valid  out  1  head entry present
- inst_ready  in  1  decode accepts head
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State:
  - fpc (8b)
  - inflight (1b) and inflight_pc (8b)
  - FIFO of DEPTH entries {inst, pc}
  - head and tail pointers, each $clog2(DEPTH) bits and wrapping
  - count
- Issue: imem_req = !rst && !redirect && (count + inflight) < DEPTH. When issuing:
  - imem_addr = fpc
  - inflight <= 1, inflight_pc <= fpc
  - fpc <= fpc + 1 (8-bit wrap: 8'hFF -> 8'h00)
- When not issuing, inflight <= 0. imem_addr still shows fpc.
- Push: if inflight is 1 and there is no redirect this cycle, write {imem_data, inflight_pc} at tail and advance tail.
- Pop: when inst_valid && inst_ready and there is no redirect, advance head.
- Push and pop in the same cycle leave count unchanged. The issue guard makes a push into a full queue impossible.
- inst_valid = (count != 0).
- inst, inst_pc and inst_pcinc show the head entry. All three are 0 when the queue is empty.
- Redirect has priority over issue, push and pop. On a redirect cycle:
  - count <= 0, head <= tail <= 0
  - inflight <= 0; any imem_data returning this cycle is discarded
  - fpc <= redirect_pc
  - imem_req = 0
- The first fetch of redirect_pc is issued the following cycle.
- A redirect asserted while the queue is empty and nothing is in flight still loads fpc.
- Reset (async): fpc <= RESET_PC; inflight, count and pointers <= 0; storage cleared.
- Reset mid-operation discards all queued and in-flight words.

## Timing
- Output values during and immediately after reset:
  - imem_req = 0 while rst is high
  - imem_addr = RESET_PC
  - inst_valid = 0, count = 0
  - inst, inst_pc, inst_pcinc = 0
- Cycle 0 = first cycle after rst deasserts: imem_req = 1, imem_addr = RESET_PC.
- Cycle 1: imem_data is valid and pushed at the end of the cycle.
- Cycle 2: inst_valid = 1.
- Fetch-to-decode latency is 2 cycles. With inst_ready held high, throughput is 1 instruction per cycle.
- Redirect at cycle R: request for redirect_pc at R+1, data at R+2, inst_valid at R+3.
- inst_valid must not drop while inst_ready is low unless a redirect or reset occurs. The head entry holds stable until it is popped.
- All outputs except imem_req come from registers or from registered FIFO state. imem_req depends combinationally only on redirect and registered state.

## Test plan
- Reset release with memory holding word k = 16'h1000 + k, inst_ready = 1:
  - imem_addr = 0, 1, 2, … on consecutive cycles
  - inst_valid first high in cycle 2 with inst = 16'h1000, inst_pc = 0, inst_pcinc = 1
  - one new instruction per cycle after that
- Backpressure, inst_ready = 0 from reset:
  - exactly 4 requests are issued (addresses 0..3), then imem_req = 0
  - count reaches 4; the head stays inst_pc = 0
  - raising inst_ready for one cycle pops one entry and produces one new request (addr 4)
- Redirect to 8'h40 while count = 3 and a fetch is in flight:
  - next cycle count = 0, inst_valid = 0, and the in-flight word is not pushed
  - imem_addr = 8'h40 with imem_req = 1 one cycle after the redirect
  - first new inst_pc = 8'h40, three cycles after the redirect
- Wrap-around: redirect to 8'hFE, then fetch 3 words:
  - inst_pc sequence FE, FF, 00
  - inst_pcinc for PC FF is 8'h00
- Simultaneous push and pop: with inst_ready toggling 1/0 over a steady fetch stream, count never exceeds 4, no entry is lost or duplicated, and inst_pc is strictly sequential.
- Async reset asserted mid-stream (count = 2, fetch in flight):
  - outputs go to their reset values immediately, without waiting for a clock edge
  - after release, fetching restarts at RESET_PC with no stale entries

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if
//   Bundles the fetch front end's memory-side and decode-side signals.
//   master : the fetch unit (drives imem_req/imem_addr and the decode outputs)
//   slave  : the surrounding core or memory (drives imem_data, redirect, inst_ready)
// Ports (all carried in the interface):
//   imem_req, imem_addr, imem_data      instruction memory request/response
//   redirect, redirect_pc               taken branch/jump from execute
//   inst, inst_pc, inst_pcinc           head instruction presented to decode
//   inst_valid, inst_ready              decode handshake
//   count                               queue occupancy
interface fetch_prefetch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [7:0]    imem_addr;
  logic [15:0]   imem_data;
  logic          redirect;
  logic [7:0]    redirect_pc;
  logic [15:0]   inst;
  logic [7:0]    inst_pc;
  logic [7:0]    inst_pcinc;
  logic          inst_valid;
  logic          inst_ready;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_pcinc, inst_valid, count,
    input  imem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_pcinc, inst_valid, count,
    output imem_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction fetch front end. Owns the fetch PC, issues addresses to a
//   synchronous (1-cycle latency) 256x16 instruction memory, buffers returned
//   words with their PCs in a DEPTH-entry queue and hands them to decode over a
//   valid/ready handshake. A redirect flushes the queue, squashes the in-flight
//   fetch and reloads the fetch PC.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fetch_prefetch_if.master (memory request/response, redirect, decode side)
module fetch_prefetch_unit #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_if.master        bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [7:0]    fpc;
  logic          inflight;
  logic [7:0]    inflight_pc;
  logic [15:0]   q_inst [DEPTH];
  logic [7:0]    q_pc   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          issue;
  logic          push;
  logic          pop;
  logic          valid;
  logic [CW:0]   occupancy;

  // Occupancy counts the in-flight word as well, so a response always has a
  // free slot waiting for it and a push into a full queue cannot happen.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    valid     = (count != '0);
    issue     = !rst && !bus.redirect && (occupancy < DEPTH_V);
    push      = inflight && !bus.redirect;
    pop       = valid && bus.inst_ready && !bus.redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 8'h00;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= 16'h0000;
        q_pc[i]   <= 8'h00;
      end
    end else if (bus.redirect) begin
      // Any word returning this cycle belongs to the squashed path and is dropped.
      fpc      <= bus.redirect_pc;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fpc;
        fpc         <= fpc + 8'd1;
      end
      if (push) begin
        q_inst[tail] <= bus.imem_data;
        q_pc[tail]   <= inflight_pc;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale storage stays behind after a flush, so the head view is forced to
  // zero whenever the queue is empty.
  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fpc;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? q_inst[head] : 16'h0000;
  assign bus.inst_pc    = valid ? q_pc[head] : 8'h00;
  assign bus.inst_pcinc = valid ? (q_pc[head] + 8'd1) : 8'h00;
  assign bus.count      = count;

endmodule
